// File: rtl/timer_sched.sv
`default_nettype none
// ============================================================================
// Module   : timer_sched
// Purpose  : Multi-channel tick timer; one shared datapath sweeps the channels.
// Revision : 1.0 - initial release
// ============================================================================
module timer_sched #(
   parameter int NCH = 4,
   parameter int PW  = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     tick,
   input  logic                     wr_en,
   input  logic [$clog2(NCH)-1:0]   wr_ch,
   input  logic [PW-1:0]            wr_period,
   input  logic                     wr_periodic,
   input  logic                     clr_ovr,
   output logic [NCH-1:0]           expire,
   output logic [NCH-1:0]           active,
   output logic                     busy,
   output logic                     overrun
);

   localparam int IW = $clog2(NCH);
   localparam logic [PW-1:0] c_one  = PW'(1);
   localparam logic [IW-1:0] c_last = IW'(NCH - 1);

   typedef enum logic [0:0] {
      S_IDLE  = 1'b0,
      S_SWEEP = 1'b1
   } state_t;

   state_t          r_state;
   logic [IW-1:0]   r_idx;
   logic            r_pending;
   logic            r_overrun;
   logic [NCH-1:0]  r_expire;
   logic [NCH-1:0]  r_active;
   logic [NCH-1:0]  r_periodic;
   logic [PW-1:0]   r_period [NCH];
   logic [PW-1:0]   r_cnt    [NCH];

   logic [PW-1:0]   w_cnt_cur;
   logic [PW-1:0]   w_cnt_dec;
   logic            w_proc;
   logic            w_wr_hit;
   logic            w_due;
   logic            w_dec;
   logic            w_last;
   logic            w_ovr_set;

   // A write to the channel under the sweep pointer suppresses its update.
   always_comb begin
      w_cnt_cur = r_cnt[r_idx];
      w_cnt_dec = w_cnt_cur - c_one;
      w_proc    = (r_state == S_SWEEP);
      w_wr_hit  = wr_en && (wr_ch == r_idx);
      w_due     = w_proc && r_active[r_idx] && (w_cnt_cur == c_one) && !w_wr_hit;
      w_dec     = w_proc && r_active[r_idx] && (w_cnt_cur >  c_one) && !w_wr_hit;
      w_last    = (r_idx == c_last);
      w_ovr_set = tick && r_pending;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state    <= S_IDLE;
         r_idx      <= '0;
         r_pending  <= 1'b0;
         r_overrun  <= 1'b0;
         r_expire   <= '0;
         r_active   <= '0;
         r_periodic <= '0;
         for (int ch = 0; ch < NCH; ch++) begin
            r_period[ch] <= '0;
            r_cnt[ch]    <= '0;
         end
      end else begin
         r_expire  <= '0;
         r_overrun <= (r_overrun && !clr_ovr) || w_ovr_set;

         case (r_state)
            S_IDLE: begin
               if (tick || r_pending) begin
                  r_state   <= S_SWEEP;
                  r_idx     <= '0;
                  r_pending <= 1'b0;
               end
            end
            S_SWEEP: begin
               if (tick) begin
                  r_pending <= 1'b1;
               end
               if (w_last) begin
                  r_state <= S_IDLE;
                  r_idx   <= '0;
               end else begin
                  r_idx <= r_idx + IW'(1);
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_idx   <= '0;
            end
         endcase

         if (wr_en) begin
            r_period[wr_ch]   <= wr_period;
            r_cnt[wr_ch]      <= wr_period;
            r_periodic[wr_ch] <= wr_periodic;
            r_active[wr_ch]   <= (wr_period != '0);
         end

         if (w_due) begin
            r_expire[r_idx] <= 1'b1;
            if (r_periodic[r_idx]) begin
               r_cnt[r_idx] <= r_period[r_idx];
            end else begin
               r_active[r_idx] <= 1'b0;
               r_cnt[r_idx]    <= '0;
            end
         end else if (w_dec) begin
            r_cnt[r_idx] <= w_cnt_dec;
         end
      end
   end

   assign busy    = (r_state != S_IDLE);
   assign expire  = r_expire;
   assign active  = r_active;
   assign overrun = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_timer_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_timer_sched
// Purpose  : Directed self-checking bench for timer_sched.
// Revision : 1.0 - initial release
// ============================================================================
module tb_timer_sched;

   localparam int NCH = 4;
   localparam int PW  = 8;

   logic            clk = 1'b0;
   logic            rst;
   logic            tick;
   logic            wr_en;
   logic [1:0]      wr_ch;
   logic [PW-1:0]   wr_period;
   logic            wr_periodic;
   logic            clr_ovr;
   logic [NCH-1:0]  expire;
   logic [NCH-1:0]  active;
   logic            busy;
   logic            overrun;

   int checks   = 0;
   int failures = 0;

   logic [NCH-1:0]  tr_exp  [0:15];
   logic            tr_busy [0:15];

   timer_sched #(.NCH(NCH), .PW(PW)) dut (
      .clk         (clk),
      .rst         (rst),
      .tick        (tick),
      .wr_en       (wr_en),
      .wr_ch       (wr_ch),
      .wr_period   (wr_period),
      .wr_periodic (wr_periodic),
      .clr_ovr     (clr_ovr),
      .expire      (expire),
      .active      (active),
      .busy        (busy),
      .overrun     (overrun)
   );

   always #5 clk = ~clk;

   task automatic step(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1; tick = 1'b0; wr_en = 1'b0; wr_ch = '0;
      wr_period = '0; wr_periodic = 1'b0; clr_ovr = 1'b0;
      step(2);
      rst = 1'b0;
      step(1);
   endtask

   task automatic write_ch(input logic [1:0] ch, input logic [PW-1:0] p, input logic per);
      wr_en = 1'b1; wr_ch = ch; wr_period = p; wr_periodic = per;
      step(1);
      wr_en = 1'b0;
   endtask

   // tr_exp[i]/tr_busy[i] hold the outputs i+1 cycles after the tick edge.
   task automatic tick_watch(input int n);
      tick = 1'b1;
      for (int i = 0; i < n; i++) begin
         step(1);
         tick = 1'b0;
         tr_exp[i]  = expire;
         tr_busy[i] = busy;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; tick = 1'b0; wr_en = 1'b0; wr_ch = '0;
      wr_period = '0; wr_periodic = 1'b0; clr_ovr = 1'b0;
      #1;
      checks++; if (expire !== 4'b0000) begin failures++; $display("FAIL reset_expire: got %b want 0000", expire); end
      checks++; if (active !== 4'b0000) begin failures++; $display("FAIL reset_active: got %b want 0000", active); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
      checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL reset_overrun: got %b want 0", overrun); end
      step(2);
      rst = 1'b0;
      step(1);
   endtask

   task automatic test_periodic();
      logic [NCH-1:0] exp;
      do_reset();
      write_ch(2'd0, 8'd3, 1'b1);
      for (int n = 1; n <= 9; n++) begin
         tick_watch(6);
         for (int i = 0; i < 6; i++) begin
            exp = (i == 1 && n % 3 == 0) ? 4'b0001 : 4'b0000;
            checks++; if (tr_exp[i] !== exp) begin failures++; $display("FAIL periodic tick%0d cyc%0d: got %b want %b", n, i + 1, tr_exp[i], exp); end
         end
         checks++; if (active !== 4'b0001) begin failures++; $display("FAIL periodic_active tick%0d: got %b want 0001", n, active); end
         step(14);
      end
   endtask

   task automatic test_oneshot();
      logic [NCH-1:0] exp;
      logic [NCH-1:0] exp_act;
      do_reset();
      write_ch(2'd2, 8'd2, 1'b0);
      for (int n = 1; n <= 4; n++) begin
         tick_watch(6);
         for (int i = 0; i < 6; i++) begin
            exp = (i == 3 && n == 2) ? 4'b0100 : 4'b0000;
            checks++; if (tr_exp[i] !== exp) begin failures++; $display("FAIL oneshot tick%0d cyc%0d: got %b want %b", n, i + 1, tr_exp[i], exp); end
         end
         exp_act = (n < 2) ? 4'b0100 : 4'b0000;
         checks++; if (active !== exp_act) begin failures++; $display("FAIL oneshot_active tick%0d: got %b want %b", n, active, exp_act); end
         step(4);
      end
   endtask

   task automatic test_back_to_back();
      // Second tick lands mid-sweep: queued, no overrun.
      do_reset();
      write_ch(2'd0, 8'd1, 1'b1);
      tick = 1'b1; step(1); tick = 1'b0;
      step(1);
      checks++; if (expire !== 4'b0001) begin failures++; $display("FAIL b2b_first_expire: got %b want 0001", expire); end
      tick = 1'b1; step(1); tick = 1'b0;
      checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL b2b_no_overrun: got %b want 0", overrun); end
      step(2);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_idle_gap: got %b want 0", busy); end
      step(1);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL b2b_restart_busy: got %b want 1", busy); end
      step(1);
      checks++; if (expire !== 4'b0001) begin failures++; $display("FAIL b2b_second_expire: got %b want 0001", expire); end
      step(5);
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL b2b_drained: got %b want 0", busy); end

      // Third tick while pending: dropped, overrun sticks until cleared.
      do_reset();
      write_ch(2'd0, 8'd1, 1'b1);
      tick = 1'b1; step(1); tick = 1'b0;
      step(1);
      tick = 1'b1; step(2); tick = 1'b0;
      checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_set: got %b want 1", overrun); end
      step(3);
      checks++; if (expire !== 4'b0001) begin failures++; $display("FAIL ovr_pending_sweep: got %b want 0001", expire); end
      for (int i = 0; i < 8; i++) begin
         step(1);
         checks++; if (expire !== 4'b0000) begin failures++; $display("FAIL ovr_dropped cyc%0d: got %b want 0000", i, expire); end
      end
      checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_sticky: got %b want 1", overrun); end
      clr_ovr = 1'b1; step(1); clr_ovr = 1'b0;
      checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_clear: got %b want 0", overrun); end

      // Clear coinciding with a fresh overrun keeps the flag set.
      tick = 1'b1; step(3);
      checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_reset_again: got %b want 1", overrun); end
      clr_ovr = 1'b1; step(1);
      checks++; if (overrun !== 1'b1) begin failures++; $display("FAIL ovr_clr_coincide: got %b want 1", overrun); end
      tick = 1'b0; step(1); clr_ovr = 1'b0;
      checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL ovr_clr_after: got %b want 0", overrun); end
      step(12);

      // Tick in the final sweep cycle: back to IDLE, then restart.
      do_reset();
      write_ch(2'd0, 8'd1, 1'b1);
      tick = 1'b1; step(1); tick = 1'b0;
      step(3);
      tick = 1'b1; step(1); tick = 1'b0;
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL last_tick_idle: got %b want 0", busy); end
      step(1);
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL last_tick_restart: got %b want 1", busy); end
      step(1);
      checks++; if (expire !== 4'b0001) begin failures++; $display("FAIL last_tick_expire: got %b want 0001", expire); end
      checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL last_tick_overrun: got %b want 0", overrun); end
      step(6);
   endtask

   task automatic test_write_collision();
      logic [NCH-1:0] exp;
      do_reset();
      write_ch(2'd1, 8'd1, 1'b1);
      tick = 1'b1; step(1); tick = 1'b0;
      step(1);
      wr_en = 1'b1; wr_ch = 2'd1; wr_period = 8'd5; wr_periodic = 1'b1;
      step(1);
      wr_en = 1'b0;
      checks++; if (expire !== 4'b0000) begin failures++; $display("FAIL collide_no_expire: got %b want 0000", expire); end
      for (int i = 0; i < 3; i++) begin
         step(1);
         checks++; if (expire !== 4'b0000) begin failures++; $display("FAIL collide_quiet cyc%0d: got %b want 0000", i, expire); end
      end
      step(10);
      for (int n = 1; n <= 5; n++) begin
         tick_watch(6);
         for (int i = 0; i < 6; i++) begin
            exp = (i == 2 && n == 5) ? 4'b0010 : 4'b0000;
            checks++; if (tr_exp[i] !== exp) begin failures++; $display("FAIL collide_reload tick%0d cyc%0d: got %b want %b", n, i + 1, tr_exp[i], exp); end
         end
         step(4);
      end
      checks++; if (active !== 4'b0010) begin failures++; $display("FAIL collide_active: got %b want 0010", active); end
   endtask

   task automatic test_disable_reload();
      logic [NCH-1:0] exp;
      do_reset();
      write_ch(2'd3, 8'd2, 1'b1);
      tick_watch(6);
      for (int i = 0; i < 6; i++) begin
         checks++; if (tr_exp[i] !== 4'b0000) begin failures++; $display("FAIL dis_first cyc%0d: got %b want 0000", i + 1, tr_exp[i]); end
      end
      write_ch(2'd3, 8'd0, 1'b1);
      checks++; if (active !== 4'b0000) begin failures++; $display("FAIL dis_active: got %b want 0000", active); end
      for (int n = 0; n < 2; n++) begin
         tick_watch(6);
         for (int i = 0; i < 6; i++) begin
            checks++; if (tr_exp[i] !== 4'b0000) begin failures++; $display("FAIL dis_silent tick%0d cyc%0d: got %b want 0000", n, i + 1, tr_exp[i]); end
         end
      end
      write_ch(2'd3, 8'd1, 1'b1);
      for (int n = 0; n < 3; n++) begin
         tick_watch(6);
         for (int i = 0; i < 6; i++) begin
            exp = (i == 4) ? 4'b1000 : 4'b0000;
            checks++; if (tr_exp[i] !== exp) begin failures++; $display("FAIL reload1 tick%0d cyc%0d: got %b want %b", n, i + 1, tr_exp[i], exp); end
         end
      end
   endtask

   task automatic test_reset_midsweep();
      int nbusy;
      do_reset();
      write_ch(2'd3, 8'd1, 1'b1);
      tick = 1'b1; step(1); tick = 1'b0;
      step(1);
      #2 rst = 1'b1;
      #1;
      checks++; if (expire !== 4'b0000) begin failures++; $display("FAIL mid_rst_expire: got %b want 0000", expire); end
      checks++; if (busy !== 1'b0) begin failures++; $display("FAIL mid_rst_busy: got %b want 0", busy); end
      checks++; if (active !== 4'b0000) begin failures++; $display("FAIL mid_rst_active: got %b want 0000", active); end
      checks++; if (overrun !== 1'b0) begin failures++; $display("FAIL mid_rst_overrun: got %b want 0", overrun); end
      for (int i = 0; i < 3; i++) begin
         step(1);
         checks++; if (expire !== 4'b0000) begin failures++; $display("FAIL mid_rst_held cyc%0d: got %b want 0000", i, expire); end
      end
      rst = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step(1);
         checks++; if (expire !== 4'b0000) begin failures++; $display("FAIL mid_rst_after cyc%0d: got %b want 0000", i, expire); end
      end
      tick_watch(6);
      nbusy = 0;
      for (int i = 0; i < 6; i++) begin
         if (tr_busy[i] === 1'b1) nbusy++;
         checks++; if (tr_exp[i] !== 4'b0000) begin failures++; $display("FAIL post_rst_sweep cyc%0d: got %b want 0000", i + 1, tr_exp[i]); end
      end
      checks++; if (nbusy != NCH) begin failures++; $display("FAIL post_rst_busy_len: got %0d want %0d", nbusy, NCH); end
      checks++; if (tr_busy[4] !== 1'b0) begin failures++; $display("FAIL post_rst_busy_end: got %b want 0", tr_busy[4]); end
   endtask

   initial begin
      test_reset();
      test_periodic();
      test_oneshot();
      test_back_to_back();
      test_write_collision();
      test_disable_reload();
      test_reset_midsweep();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
